// File: rtl/adc_frame_scheduler_if.sv
// Channel-sample inputs and AXI-Stream output of the ADC frame scheduler.
// The master modport is the scheduler side; the slave modport is the environment side.
interface adc_frame_scheduler_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DW     = 32
);
  logic [NUM_CH*DW-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH-1:0]    ch_ack;
  logic [NUM_CH*DW-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;

  modport master (
    input  ch_data, ch_valid, m_axis_tready,
    output ch_ack, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output ch_data, ch_valid, m_axis_tready,
    input  ch_ack, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/adc_frame_scheduler.sv
// Packs one sample per ADC channel into a beat and emits framed AXI-Stream output.
// A frame is cfg_frame_len beats long. A stop request takes effect at the next frame boundary.
module adc_frame_scheduler #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DW     = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_W-1:0]     cfg_frame_len,
  adc_frame_scheduler_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [LEN_W-1:0]     stall_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [LEN_W-1:0]     stall_q, stall_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 ack_guard_q;
  logic                 tvalid_q, tlast_q, frame_done_q;
  logic [NUM_CH*DW-1:0] tdata_q;
  logic [NUM_CH-1:0]    ch_ack_q;

  logic all_valid, slot_free, capture, handshake, last_beat, stall_hit;

  assign all_valid = &bus.ch_valid;
  assign slot_free = !tvalid_q || bus.m_axis_tready;
  assign capture   = (state_q == ST_RUN) && all_valid && slot_free && !ack_guard_q;
  assign handshake = tvalid_q && bus.m_axis_tready;
  assign last_beat = (beat_q == len_q - LEN_W'(1));
  // The guard cycle is not a stall: sources are still withdrawing the consumed sample.
  assign stall_hit = (state_q == ST_RUN) && all_valid && !ack_guard_q && !slot_free;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_d      = beat_q;
    stall_d     = stall_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;
          beat_d      = '0;
          stall_d     = '0;
          // start together with stop yields exactly one frame
          stop_pend_d = stop;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (stall_hit && (stall_q != '1)) stall_d = stall_q + LEN_W'(1);
        if (capture) begin
          beat_d = last_beat ? '0 : beat_q + LEN_W'(1);
          if (last_beat && (stop_pend_q || stop)) begin
            stop_pend_d = 1'b0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (handshake && tlast_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_W'(1);
      beat_q      <= '0;
      stall_q     <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      ch_ack_q     <= '0;
      ack_guard_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (capture) begin
        tdata_q  <= bus.ch_data;
        tvalid_q <= 1'b1;
        tlast_q  <= last_beat;
      end else if (handshake) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      ch_ack_q     <= {NUM_CH{capture}};
      ack_guard_q  <= capture;
      frame_done_q <= handshake && tlast_q;
    end
  end

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.ch_ack        = ch_ack_q;
  assign busy              = (state_q != ST_IDLE);
  assign frame_done        = frame_done_q;
  assign stall_cnt         = stall_q;

endmodule
